// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word stores and an asynchronous read port.
// Stores are range- and alignment-checked; a rejected store raises storeErr and writes nothing.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [1:0]  storeType,
  output logic [31:0] RD,
  output logic [3:0]  byteEn,
  output logic        storeErr
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33 bits so that ADDR_BASE + size reaching 2^32 still compares correctly.
  localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] StNone = 2'd0;
  localparam logic [1:0] StWord = 2'd1;
  localparam logic [1:0] StHalf = 2'd2;
  localparam logic [1:0] StByte = 2'd3;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     offset;
  logic            inRange;
  logic [IdxW-1:0] wordIdx;
  logic [3:0]      rawEn;
  logic            misaligned;
  logic [31:0]     laneData;

  // Byte offset from the window base; the A >= ADDR_BASE term keeps a wrapped
  // subtraction from aliasing low addresses onto stored words.
  assign offset  = A - ADDR_BASE;
  assign inRange = (A >= ADDR_BASE) && ({1'b0, offset} < MemBytes);
  assign wordIdx = offset[IdxW+1:2];

  // Asynchronous read of the addressed word; out-of-range reads return zero.
  always_comb begin
    RD = '0;
    if (inRange) begin
      RD = mem[wordIdx];
    end
  end

  // Decode store kind into lane enables, alignment check and replicated lane data.
  always_comb begin
    rawEn      = 4'b0000;
    misaligned = 1'b0;
    laneData   = WD;
    unique case (storeType)
      StNone: begin
        rawEn = 4'b0000;
      end
      StWord: begin
        rawEn      = 4'b1111;
        misaligned = (A[1:0] != 2'b00);
        laneData   = WD;
      end
      StHalf: begin
        rawEn      = A[1] ? 4'b1100 : 4'b0011;
        misaligned = A[0];
        laneData   = {WD[15:0], WD[15:0]};
      end
      StByte: begin
        rawEn    = 4'b0001 << A[1:0];
        laneData = {4{WD[7:0]}};
      end
      default: begin
        rawEn = 4'b0000;
      end
    endcase
  end

  // Error qualification; a rejected store drives no lane enables.
  always_comb begin
    storeErr = (storeType != StNone) && (!inRange || misaligned);
    byteEn   = storeErr ? 4'b0000 : rawEn;
  end

  // Storage update: reset clears every word and overrides any store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (byteEn[l]) begin
          mem[wordIdx][8*l +: 8] <= laneData[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios followed by random traffic, all
// compared against a byte-addressed reference model. A second, small instance with a
// non-zero base exercises the window offset and both range boundaries.
module tb_data_mem;

  localparam logic [31:0] Base1  = 32'h0000_0000;
  localparam int unsigned Bytes1 = 4096 * 4;
  localparam logic [31:0] Base2  = 32'h0000_0100;
  localparam int unsigned Bytes2 = 16 * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] WD;
  logic [1:0]  storeType;
  logic [31:0] RD1, RD2;
  logic [3:0]  byteEn1, byteEn2;
  logic        storeErr1, storeErr2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m1 [Bytes1];
  logic [7:0] m2 [Bytes2];

  logic [31:0] lastRd;
  logic [3:0]  lastEn;
  logic        lastErr;

  data_mem #(.DEPTH_WORDS(4096), .ADDR_BASE(Base1)) dut (
    .clk(clk), .reset(reset), .A(A), .WD(WD), .storeType(storeType),
    .RD(RD1), .byteEn(byteEn1), .storeErr(storeErr1)
  );

  data_mem #(.DEPTH_WORDS(16), .ADDR_BASE(Base2)) dut2 (
    .clk(clk), .reset(reset), .A(A), .WD(WD), .storeType(storeType),
    .RD(RD2), .byteEn(byteEn2), .storeErr(storeErr2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sizeOf(input logic [1:0] st);
    return (st == 2'd1) ? 4 : (st == 2'd2) ? 2 : 1;
  endfunction

  function automatic bit inWin(input logic [31:0] a, input logic [31:0] base, input int unsigned n);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(base);
    return (la >= lb) && (la < lb + longint'(n));
  endfunction

  // {err, mask}: a store of 'size' bytes starting at a must lie in the window and be size-aligned.
  function automatic logic [4:0] expStore(input logic [31:0] a, input logic [1:0] st,
                                          input logic [31:0] base, input int unsigned n);
    int  sz;
    bit  err;
    int  mask;
    if (st == 2'd0) return 5'b0;
    sz   = sizeOf(st);
    err  = !inWin(a, base, n) || ((a % sz) != 0);
    mask = err ? 0 : (((1 << sz) - 1) << (a % 4));
    return {err, mask[3:0]};
  endfunction

  function automatic logic [31:0] read1(input logic [31:0] a);
    int unsigned o;
    if (!inWin(a, Base1, Bytes1)) return 32'h0;
    o = (a - Base1) & ~32'h3;
    return {m1[o+3], m1[o+2], m1[o+1], m1[o]};
  endfunction

  function automatic logic [31:0] read2(input logic [31:0] a);
    int unsigned o;
    if (!inWin(a, Base2, Bytes2)) return 32'h0;
    o = (a - Base2) & ~32'h3;
    return {m2[o+3], m2[o+2], m2[o+1], m2[o]};
  endfunction

  // One access: drive, check combinational outputs mid-cycle, clock, update the model.
  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] st, input bit doChk);
    logic [4:0] e1, e2;
    int sz;
    reset = r; A = a; WD = wd; storeType = st;
    #3;
    e1 = expStore(a, st, Base1, Bytes1);
    e2 = expStore(a, st, Base2, Bytes2);
    lastRd = RD1; lastEn = byteEn1; lastErr = storeErr1;
    if (doChk) begin
      chk("rd1",  RD1, read1(a));
      chk("en1",  {28'b0, byteEn1}, {28'b0, e1[3:0]});
      chk("err1", {31'b0, storeErr1}, {31'b0, e1[4]});
      chk("rd2",  RD2, read2(a));
      chk("en2",  {28'b0, byteEn2}, {28'b0, e2[3:0]});
      chk("err2", {31'b0, storeErr2}, {31'b0, e2[4]});
    end
    @(posedge clk);
    sz = sizeOf(st);
    if (r) begin
      foreach (m1[i]) m1[i] = 8'h0;
      foreach (m2[i]) m2[i] = 8'h0;
    end else if (st != 2'd0) begin
      for (int k = 0; k < sz; k++) begin
        if (!e1[4]) m1[a - Base1 + k] = wd[8*k +: 8];
        if (!e2[4]) m2[a - Base2 + k] = wd[8*k +: 8];
      end
    end
    #1;
  endtask

  task automatic rdCyc(input logic [31:0] a);
    cyc(1'b0, a, 32'h0, 2'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  st;
    logic        r;
    int          region;
    reset = 1'b1; A = '0; WD = '0; storeType = '0;
    @(posedge clk); #1;
    cyc(1'b1, 32'h0, 32'h0, 2'd0, 1'b0);
    cyc(1'b1, 32'h0, 32'h0, 2'd0, 1'b0);

    // Reset state
    rdCyc(32'h0000_0010); chk("rst_rd_10", lastRd, 32'h0);
    rdCyc(32'h0000_3FFC); chk("rst_rd_top", lastRd, 32'h0);
    rdCyc(32'h0000_0104);

    // Word store then partial merges
    cyc(1'b0, 32'h10, 32'h1234_5678, 2'd1, 1'b1); chk("sw_en", {28'b0, lastEn}, 32'hF);
    rdCyc(32'h10); chk("sw_rd", lastRd, 32'h1234_5678);
    cyc(1'b0, 32'h12, 32'h0000_00AB, 2'd3, 1'b1); chk("sb_en", {28'b0, lastEn}, 32'h4);
    rdCyc(32'h10); chk("sb_rd", lastRd, 32'h12AB_5678);
    cyc(1'b0, 32'h10, 32'hFFFF_CDEF, 2'd2, 1'b1); chk("sh_en", {28'b0, lastEn}, 32'h3);
    rdCyc(32'h10); chk("sh_rd", lastRd, 32'h12AB_CDEF);

    // Misaligned stores are suppressed
    cyc(1'b0, 32'h22, 32'hAAAA_AAAA, 2'd1, 1'b1);
    chk("sw_mis_err", {31'b0, lastErr}, 32'h1); chk("sw_mis_en", {28'b0, lastEn}, 32'h0);
    cyc(1'b0, 32'h13, 32'hBBBB_BBBB, 2'd2, 1'b1);
    chk("sh_mis_err", {31'b0, lastErr}, 32'h1); chk("sh_mis_en", {28'b0, lastEn}, 32'h0);
    rdCyc(32'h20); chk("mis_rd_20", lastRd, 32'h0);
    rdCyc(32'h10); chk("mis_rd_10", lastRd, 32'h12AB_CDEF);

    // Top boundary of the default window
    cyc(1'b0, 32'h3FFF, 32'h55, 2'd3, 1'b1); chk("top_sb_err", {31'b0, lastErr}, 32'h0);
    rdCyc(32'h3FFC); chk("top_rd", lastRd, 32'h5500_0000);
    cyc(1'b0, 32'h4000, 32'h1111_2222, 2'd1, 1'b1); chk("past_err", {31'b0, lastErr}, 32'h1);
    rdCyc(32'h4000); chk("past_rd", lastRd, 32'h0);
    rdCyc(32'h0000_0000); chk("nowrap_rd0", lastRd, 32'h0);

    // Small window: both edges and the last byte
    cyc(1'b0, 32'h13F, 32'h77, 2'd3, 1'b1);
    cyc(1'b0, 32'h140, 32'h88, 2'd3, 1'b1);
    cyc(1'b0, 32'h0FF, 32'h99, 2'd3, 1'b1);
    cyc(1'b0, 32'h100, 32'hCAFE_F00D, 2'd1, 1'b1);
    rdCyc(32'h13C); rdCyc(32'h100); rdCyc(32'h140);

    // Reset dominates a concurrent store
    cyc(1'b1, 32'h20, 32'hDEAD_BEEF, 2'd1, 1'b1);
    rdCyc(32'h20); chk("rst_dom_rd", lastRd, 32'h0);
    rdCyc(32'h10); chk("rst_clr_rd", lastRd, 32'h0);

    // Back-to-back stores: old word visible during each store cycle
    cyc(1'b0, 32'h30, 32'h1111_1111, 2'd1, 1'b1); chk("b2b_old0", lastRd, 32'h0);
    cyc(1'b0, 32'h30, 32'h2222_2222, 2'd1, 1'b1); chk("b2b_old1", lastRd, 32'h1111_1111);
    rdCyc(32'h30); chk("b2b_new", lastRd, 32'h2222_2222);
    cyc(1'b0, 32'h31, 32'h0000_00EE, 2'd3, 1'b1);
    cyc(1'b0, 32'h32, 32'h0000_9876, 2'd2, 1'b1);
    rdCyc(32'h30); chk("b2b_merge", lastRd, 32'h9876_EE22);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      region = $urandom_range(0, 9);
      if (region < 4)      a = $urandom_range(32'hF0, 32'h150);
      else if (region < 7) a = $urandom_range(32'h3FE0, 32'h4010);
      else if (region < 9) a = $urandom_range(32'h0, 32'h60);
      else                 a = $urandom;
      wd = $urandom;
      st = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 59) == 0);
      cyc(r, a, wd, st, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
